// File: rtl/load_store_unit.sv
// Byte-wide load/store unit: 256-byte mirrored RAM plus an I/O page with
// three output ports and an optional serial-in shift register (LSU_SERIAL_EN).
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  d,
    input  logic [15:0] a,
    input  logic        re,
    input  logic        we,
    input  logic        sp_d,
    input  logic        sp_we,
    input  logic        sp_en,
    output logic [7:0]  q,
    output logic [7:0]  q1,
    output logic [7:0]  q2,
    output logic [7:0]  q3,
    output logic [7:0]  fo
);

    logic [7:0] mem [0:255];
    logic [7:0] rd_data;
    logic [7:0] serial_rd;
    logic       ram_sel;
    logic       io_sel;

    assign ram_sel = ~a[15];
    // 0x8000..0x8003; everything else above 0x7FFF is unmapped.
    assign io_sel  = (a[15:2] == 14'h2000);

`ifdef LSU_SERIAL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fo <= 8'h00;
        end else if (sp_en && sp_we) begin
            fo <= {fo[6:0], sp_d};
        end
    end

    assign serial_rd = fo;
`else
    logic unused_serial;

    assign unused_serial = ^{sp_d, sp_we, sp_en};
    assign fo            = 8'h00;
    assign serial_rd     = 8'h00;
`endif

    // NOTE: every output of an always_comb gets a default first so no latch
    // is inferred on paths that do not assign it.
    always_comb begin
        rd_data = 8'h00;
        if (ram_sel) begin
            rd_data = mem[a[7:0]];
        end else if (io_sel) begin
            case (a[1:0])
                2'd0:    rd_data = serial_rd;
                2'd1:    rd_data = q1;
                2'd2:    rd_data = q2;
                default: rd_data = q3;
            endcase
        end
    end

    // NOTE: the RAM array has no reset; contents survive rst and only the
    // store path writes it, which keeps it mappable onto block memory.
    always_ff @(posedge clk) begin
        if (!rst && we && ram_sel) begin
            mem[a[7:0]] <= d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values, giving the pre-update read of I/O registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 8'h00;
        end else if (re && !we) begin
            q <= rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= 8'h00;
            q2 <= 8'h00;
            q3 <= 8'h00;
        end else if (we && io_sel) begin
            case (a[1:0])
                2'd1:    q1 <= d;
                2'd2:    q2 <= d;
                2'd3:    q3 <= d;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed plan steps followed by
// randomized traffic, all compared against a behavioural address-map model.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  d;
    logic [15:0] a;
    logic        re;
    logic        we;
    logic        sp_d;
    logic        sp_we;
    logic        sp_en;
    logic [7:0]  q;
    logic [7:0]  q1;
    logic [7:0]  q2;
    logic [7:0]  q3;
    logic [7:0]  fo;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [7:0] m_ram [0:255];
    logic [7:0] m_q, m_q1, m_q2, m_q3, m_fo;

    load_store_unit dut (
        .clk   (clk),
        .rst   (rst),
        .d     (d),
        .a     (a),
        .re    (re),
        .we    (we),
        .sp_d  (sp_d),
        .sp_we (sp_we),
        .sp_en (sp_en),
        .q     (q),
        .q1    (q1),
        .q2    (q2),
        .q3    (q3),
        .fo    (fo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input int addr);
        if (addr < 32'h8000)       return m_ram[addr % 256];
`ifdef LSU_SERIAL_EN
        else if (addr == 32'h8000) return m_fo;
`endif
        else if (addr == 32'h8001) return m_q1;
        else if (addr == 32'h8002) return m_q2;
        else if (addr == 32'h8003) return m_q3;
        else                       return 8'h00;
    endfunction

    // One clock: drive inputs, advance the model, then compare every output.
    task automatic step(input logic r, input int addr, input logic [7:0] data,
                        input logic rd, input logic wr,
                        input logic sd, input logic swe, input logic sen);
        logic [7:0] rv;
        rst = r; a = addr[15:0]; d = data; re = rd; we = wr;
        sp_d = sd; sp_we = swe; sp_en = sen;
        rv = m_read(addr);
        @(posedge clk);
        if (r) begin
            m_q = 0; m_q1 = 0; m_q2 = 0; m_q3 = 0; m_fo = 0;
        end else begin
            if (rd && !wr) m_q = rv;
            if (wr) begin
                if (addr < 32'h8000)       m_ram[addr % 256] = data;
                else if (addr == 32'h8001) m_q1 = data;
                else if (addr == 32'h8002) m_q2 = data;
                else if (addr == 32'h8003) m_q3 = data;
            end
`ifdef LSU_SERIAL_EN
            if (sen && swe) m_fo = 8'((m_fo * 2 + int'(sd)) % 256);
`endif
        end
        #1;
        check("q",  q,  m_q);
        check("q1", q1, m_q1);
        check("q2", q2, m_q2);
        check("q3", q3, m_q3);
        check("fo", fo, m_fo);
    endtask

    // Expected serial contents depend on whether the shifter is built.
    function automatic logic [7:0] fo_exp(input logic [7:0] v);
`ifdef LSU_SERIAL_EN
        return v;
`else
        return 8'h00 & v;
`endif
    endfunction

    initial begin
        m_q = 0; m_q1 = 0; m_q2 = 0; m_q3 = 0; m_fo = 0;

        // Reset, then read the I/O page.
        step(1, 16'h0000, 8'h00, 0, 0, 0, 0, 0);
        step(0, 16'h8000, 8'h00, 1, 0, 0, 0, 0);
        check("plan_rd8000", q, 8'h00);
        step(0, 16'h8001, 8'h00, 1, 0, 0, 0, 0);
        check("plan_rd8001", q, 8'h00);

        // Basic RAM store/load.
        step(0, 16'h0000, 8'h64, 0, 1, 0, 0, 0);
        step(0, 16'h0000, 8'h00, 1, 0, 0, 0, 0);
        check("plan_ld0", q, 8'h64);
        step(0, 16'h001E, 8'h30, 0, 1, 0, 0, 0);
        step(0, 16'h0000, 8'h00, 1, 0, 0, 0, 0);
        check("plan_ld0_again", q, 8'h64);
        step(0, 16'h001E, 8'h00, 1, 0, 0, 0, 0);
        check("plan_ld1e", q, 8'h30);

        // Serial shifting: three ones then two zeros.
        for (int i = 0; i < 3; i++) step(0, 16'h0000, 8'h00, 0, 0, 1, 1, 1);
        check("plan_fo07", fo, fo_exp(8'h07));
        for (int i = 0; i < 2; i++) step(0, 16'h0000, 8'h00, 0, 0, 0, 1, 1);
        check("plan_fo1c", fo, fo_exp(8'h1C));
        step(0, 16'h8000, 8'h00, 1, 0, 0, 0, 0);
        check("plan_ld8000", q, fo_exp(8'h1C));
        step(0, 16'h0000, 8'h00, 0, 0, 1, 0, 1);
        check("plan_fo_hold", fo, fo_exp(8'h1C));
        // Load of fo in the same cycle as a shift returns the pre-shift value.
        step(0, 16'h8000, 8'h00, 1, 0, 1, 1, 1);
        check("plan_ld_pre_shift", q, fo_exp(8'h1C));

        // Port writes, fo write ignored, unmapped read.
        step(0, 16'h8002, 8'hA5, 0, 1, 0, 0, 0);
        check("plan_q2", q2, 8'hA5);
        check("plan_q1", q1, 8'h00);
        step(0, 16'h8000, 8'hFF, 0, 1, 0, 0, 0);
        check("plan_fo_nowrite", fo, fo_exp(8'h39));
        step(0, 16'h9000, 8'h00, 1, 0, 0, 0, 0);
        check("plan_unmapped", q, 8'h00);

        // Reset while shifting; RAM must survive.
        step(1, 16'h0000, 8'h77, 0, 1, 1, 1, 1);
        check("plan_rst_q2", q2, 8'h00);
        check("plan_rst_fo", fo, 8'h00);
        step(0, 16'h0000, 8'h00, 1, 0, 0, 0, 0);
        check("plan_ram_kept", q, 8'h64);

        // Mirroring and simultaneous re/we.
        step(0, 16'h0105, 8'h33, 0, 1, 0, 0, 0);
        step(0, 16'h0005, 8'h00, 1, 0, 0, 0, 0);
        check("plan_mirror", q, 8'h33);
        step(0, 16'h0005, 8'h5A, 1, 1, 0, 0, 0);
        check("plan_rewe_hold", q, 8'h33);
        step(0, 16'h7F05, 8'h00, 1, 0, 0, 0, 0);
        check("plan_rewe_store", q, 8'h5A);

        // Fill the RAM so random loads never see uninitialised bytes.
        for (int i = 0; i < 256; i++)
            step(0, i, 8'($urandom), 0, 1, 0, 0, 0);

        // Randomized traffic over the whole map.
        for (int i = 0; i < 400; i++) begin
            int addr;
            case ($urandom_range(0, 3))
                0, 1:    addr = $urandom_range(0, 32'h7FFF);
                2:       addr = 32'h8000 + $urandom_range(0, 5);
                default: addr = $urandom_range(32'h8000, 32'hFFFF);
            endcase
            step(($urandom_range(0, 31) == 0), addr, 8'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
